// File: rtl/mc_maindec_pkg.sv
// Shared encodings for the multicycle main decoder, ALU decoder and datapath.
package mc_maindec_pkg;

    // Controller states; values 12..15 are unused and recover to fetch.
    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StRtypeWb = 4'd7,
        StBeqEx   = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJEx     = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_REG   = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // 15-bit control word produced for every state.
    typedef struct packed {
        logic       iord;
        logic       alusrca;
        logic       regdst;
        logic       memtoreg;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       memwrite;
        logic       regwrite;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_supported = 1'b1;
            default:                                      op_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_maindec_outdec.sv
// State to control-word decoder for the multicycle main decoder.
module mc_maindec_outdec
    import mc_maindec_pkg::*;
(
    input  state_e state,
    output ctrl_t  ctrl
);

    // Moore decode; anything not set for a state (or an unused encoding) stays 0.
    always_comb begin
        ctrl = '0;
        case (state)
            StFetch: begin
                ctrl.alusrcb = ALUSRCB_FOUR;
                ctrl.irwrite = 1'b1;
                ctrl.pcwrite = 1'b1;
            end
            StDecode: ctrl.alusrcb = ALUSRCB_IMMSH;
            StMemAdr: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUSRCB_IMM;
            end
            StMemRd: ctrl.iord = 1'b1;
            StMemWb: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            StMemWr: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            StRtypeEx: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            StRtypeWb: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            StBeqEx: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                ctrl.branch  = 1'b1;
            end
            StAddiEx: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUSRCB_IMM;
            end
            StAddiWb: ctrl.regwrite = 1'b1;
            StJEx: begin
                ctrl.pcsrc   = PCSRC_JUMP;
                ctrl.pcwrite = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle main decoder: state register, next-state logic, sticky illegal flag.
module mc_maindec
    import mc_maindec_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    output logic       iord,
    output logic       alusrca,
    output logic       regdst,
    output logic       memtoreg,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       memwrite,
    output logic       regwrite,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal
);

    state_e state_q, state_d;
    logic   illegal_q;
    ctrl_t  ctrl;

    // Next-state selection; op is only consulted in decode and memory-address states.
    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (op)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_RTYPE:     state_d = StRtypeEx;
                    OP_BEQ:       state_d = StBeqEx;
                    OP_ADDI:      state_d = StAddiEx;
                    OP_J:         state_d = StJEx;
                    default:      state_d = StFetch;
                endcase
            end
            StMemAdr:  state_d = (op == OP_SW) ? StMemWr : StMemRd;
            StMemRd:   state_d = StMemWb;
            StRtypeEx: state_d = StRtypeWb;
            StAddiEx:  state_d = StAddiWb;
            default:   state_d = StFetch;
        endcase
    end

    // State register and sticky illegal-opcode flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode && !op_supported(op)) begin
                illegal_q <= 1'b1;
            end
        end
    end

    mc_maindec_outdec u_outdec (
        .state (state_q),
        .ctrl  (ctrl)
    );

    // Mux selects pass straight through; write enables are held off during reset so no
    // write can land while the machine is being forced back to fetch.
    assign iord     = ctrl.iord;
    assign alusrca  = ctrl.alusrca;
    assign regdst   = ctrl.regdst;
    assign memtoreg = ctrl.memtoreg;
    assign alusrcb  = ctrl.alusrcb;
    assign pcsrc    = ctrl.pcsrc;
    assign aluop    = ctrl.aluop;
    assign irwrite  = ctrl.irwrite  & ~reset;
    assign pcwrite  = ctrl.pcwrite  & ~reset;
    assign branch   = ctrl.branch   & ~reset;
    assign memwrite = ctrl.memwrite & ~reset;
    assign regwrite = ctrl.regwrite & ~reset;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_mc_maindec.sv
// Randomized self-checking bench for mc_maindec with an instruction-level reference model.
module tb_mc_maindec;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       iord, alusrca, regdst, memtoreg, irwrite, pcwrite, branch, memwrite, regwrite;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic       illegal;

    int checks   = 0;
    int failures = 0;

    mc_maindec dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .iord     (iord),
        .alusrca  (alusrca),
        .regdst   (regdst),
        .memtoreg (memtoreg),
        .irwrite  (irwrite),
        .pcwrite  (pcwrite),
        .branch   (branch),
        .memwrite (memwrite),
        .regwrite (regwrite),
        .alusrcb  (alusrcb),
        .pcsrc    (pcsrc),
        .aluop    (aluop),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    // Bit layout: 15 illegal, 14 iord, 13 alusrca, 12 regdst, 11 memtoreg, 10 irwrite,
    // 9 pcwrite, 8 branch, 7 memwrite, 6 regwrite, 5:4 alusrcb, 3:2 pcsrc, 1:0 aluop.
    logic [15:0] dut_vec;
    assign dut_vec = {illegal, iord, alusrca, regdst, memtoreg, irwrite, pcwrite, branch,
                      memwrite, regwrite, alusrcb, pcsrc, aluop};

    typedef enum int {KLw, KSw, KR, KBeq, KAddi, KJ, KIll} kind_t;

    function automatic kind_t classify(input logic [5:0] o);
        case (o)
            6'b100011: return KLw;
            6'b101011: return KSw;
            6'b000000: return KR;
            6'b000100: return KBeq;
            6'b001000: return KAddi;
            6'b000010: return KJ;
            default:   return KIll;
        endcase
    endfunction

    function automatic int cpi_of(input kind_t k);
        case (k)
            KLw:            return 5;
            KSw, KR, KAddi: return 4;
            KBeq, KJ:       return 3;
            default:        return 2;
        endcase
    endfunction

    // Expected outputs for step s (0 = fetch, 1 = decode) of an instruction of kind k.
    function automatic logic [15:0] model_out(input int s, input kind_t k, input logic rst,
                                              input logic ill);
        logic [15:0] v;
        v = '0;
        if (s == 0) begin
            v[5:4] = 2'b01; v[10] = 1'b1; v[9] = 1'b1;
        end else if (s == 1) begin
            v[5:4] = 2'b11;
        end else begin
            case (k)
                KLw, KSw: begin
                    if (s == 2) begin
                        v[13] = 1'b1; v[5:4] = 2'b10;
                    end else if (k == KSw) begin
                        v[14] = 1'b1; v[7] = 1'b1;
                    end else if (s == 3) begin
                        v[14] = 1'b1;
                    end else begin
                        v[11] = 1'b1; v[6] = 1'b1;
                    end
                end
                KR: begin
                    if (s == 2) begin
                        v[13] = 1'b1; v[1:0] = 2'b10;
                    end else begin
                        v[12] = 1'b1; v[6] = 1'b1;
                    end
                end
                KBeq: begin
                    v[13] = 1'b1; v[1:0] = 2'b01; v[3:2] = 2'b01; v[8] = 1'b1;
                end
                KAddi: begin
                    if (s == 2) begin
                        v[13] = 1'b1; v[5:4] = 2'b10;
                    end else begin
                        v[6] = 1'b1;
                    end
                end
                KJ: begin
                    v[3:2] = 2'b10; v[9] = 1'b1;
                end
                default: v = '0;
            endcase
        end
        if (rst) v[10:6] = '0;
        v[15] = ill;
        return v;
    endfunction

    // Reference model: position within the current instruction plus sticky flag.
    int    m_step = 0;
    kind_t m_kind = KIll;
    logic  m_ill  = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_step <= 0;
            m_ill  <= 1'b0;
        end else if (m_step == 0) begin
            m_step <= 1;
        end else if (m_step == 1) begin
            if (classify(op) == KIll) begin
                m_ill  <= 1'b1;
                m_step <= 0;
            end else begin
                m_kind <= classify(op);
                m_step <= 2;
            end
        end else if (m_step + 1 >= cpi_of(m_kind)) begin
            m_step <= 0;
        end else begin
            m_step <= m_step + 1;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        check("cycle_cmp", {16'h0, dut_vec}, {16'h0, model_out(m_step, m_kind, reset, m_ill)});
    end

    // Run one instruction starting in fetch; returns cycles until the next fetch and a trace.
    task automatic issue(input logic [5:0] o, output int n, output logic [15:0] tr [8]);
        for (int i = 0; i < 8; i++) tr[i] = '0;
        op    = o;
        n     = 0;
        tr[0] = dut_vec;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n < 8) tr[n] = dut_vec;
        end while (irwrite !== 1'b1 && n < 10);
    endtask

    int          n;
    logic [15:0] tr [8];
    logic [5:0]  o;

    initial begin
        reset = 1'b1;
        op    = 6'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_enables", {27'h0, irwrite, pcwrite, memwrite, regwrite, branch}, 32'h0);
        check("rst_alusrcb", {30'h0, alusrcb}, 32'h1);
        check("rst_illegal", {31'h0, illegal}, 32'h0);
        reset = 1'b0;
        #1;
        check("first_fetch", {30'h0, pcwrite, irwrite}, 32'h3);

        issue(6'b100011, n, tr);
        check("lw_cpi", n, 5);
        check("lw_iord", {27'h0, tr[0][14], tr[1][14], tr[2][14], tr[3][14], tr[4][14]}, 32'h02);
        check("lw_regwr", {27'h0, tr[0][6], tr[1][6], tr[2][6], tr[3][6], tr[4][6]}, 32'h01);
        check("lw_memtoreg", {27'h0, tr[0][11], tr[1][11], tr[2][11], tr[3][11], tr[4][11]},
              32'h01);
        check("lw_aluop", {30'h0, tr[0][1:0] | tr[1][1:0] | tr[2][1:0] | tr[3][1:0] | tr[4][1:0]},
              32'h0);

        issue(6'b000000, n, tr);
        check("r_cpi", n, 4);
        check("r_aluop", {30'h0, tr[2][1:0]}, 32'h2);
        check("r_alusrcb", {30'h0, tr[2][5:4]}, 32'h0);
        check("r_wb", {30'h0, tr[3][12], tr[3][6]}, 32'h3);

        issue(6'b000100, n, tr);
        check("beq_cpi", n, 3);
        check("beq_branch", {29'h0, tr[0][8], tr[1][8], tr[2][8]}, 32'h1);
        check("beq_pcsrc", {30'h0, tr[2][3:2]}, 32'h1);
        check("beq_aluop", {30'h0, tr[2][1:0]}, 32'h1);

        issue(6'b000010, n, tr);
        check("j_cpi", n, 3);
        check("j_pcsrc", {30'h0, tr[2][3:2]}, 32'h2);
        check("j_pcwrite", {30'h0, tr[1][9], tr[2][9]}, 32'h1);

        issue(6'b111111, n, tr);
        check("ill_cpi", n, 2);
        check("ill_flag", {31'h0, illegal}, 32'h1);

        issue(6'b001000, n, tr);
        check("addi_cpi", n, 4);
        check("addi_alusrcb", {30'h0, tr[2][5:4]}, 32'h2);
        check("addi_regwr", {31'h0, tr[3][6]}, 32'h1);
        check("addi_ill_sticky", {31'h0, illegal}, 32'h1);

        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_clears_ill", {31'h0, illegal}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 7))
                0:       o = 6'b100011;
                1:       o = 6'b101011;
                2:       o = 6'b000000;
                3:       o = 6'b000100;
                4:       o = 6'b001000;
                5:       o = 6'b000010;
                default: o = 6'($urandom_range(0, 63));
            endcase
            issue(o, n, tr);
            check("rand_cpi", n, cpi_of(classify(o)));
        end

        // Asynchronous reset while a store is writing memory.
        op = 6'b101011;
        n  = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (memwrite !== 1'b1 && n < 10);
        check("sw_reach_memwr", n, 3);
        #2;
        reset = 1'b1;
        #1;
        check("async_memwrite", {31'h0, memwrite}, 32'h0);
        check("async_enables", {28'h0, irwrite, pcwrite, regwrite, branch}, 32'h0);
        check("async_fetch_alusrcb", {30'h0, alusrcb}, 32'h1);
        check("async_iord", {31'h0, iord}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_async_fetch", {30'h0, pcwrite, irwrite}, 32'h3);
        issue(6'b000100, n, tr);
        check("post_async_beq_cpi", n, 3);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
